// File: rtl/evo_harness_pkg.sv
// Shared types and helpers for the evolved-circuit response harness.
package evo_harness_pkg;

    // Sweep sequencer states.
    typedef enum logic [2:0] {
        StIdle,
        StSettle,
        StSample,
        StReport,
        StDone
    } state_e;

    // Width of a counter that must hold the value `samples` exactly.
    function automatic int unsigned cnt_w(input int unsigned samples);
        return $clog2(samples + 1);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchronizer for a single asynchronous DUT output.
module bit_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    // Shift the asynchronous input through two flops; reset clears both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/evo_response_sampler.sv
// Sweeps every input vector into an evolved circuit, settles, samples its
// output and reports ones/toggle counts per vector over a valid/ready port.
module evo_response_sampler
    import evo_harness_pkg::*;
#(
    parameter int unsigned IN_WIDTH      = 2,
    parameter int unsigned SETTLE_CYCLES = 16,
    parameter int unsigned SAMPLES       = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         start,
    output logic                         busy,
    output logic                         done,
    output logic [IN_WIDTH-1:0]          dut_in,
    input  logic                         dut_out,
    output logic                         result_valid,
    input  logic                         result_ready,
    output logic [IN_WIDTH-1:0]          result_vec,
    output logic [cnt_w(SAMPLES)-1:0]    result_ones,
    output logic [cnt_w(SAMPLES)-1:0]    result_toggles,
    output logic                         result_value,
    output logic                         result_stable
);

    localparam int unsigned CW = cnt_w(SAMPLES);
    localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);

    state_e              state_q, state_d;
    logic [IN_WIDTH-1:0] vec_q;
    logic [SW-1:0]       settle_q;
    logic [CW-1:0]       samp_q;
    logic [CW-1:0]       ones_q;
    logic [CW-1:0]       tog_q;
    logic                prev_q;
    logic                dut_sync;
    logic                settle_last;
    logic                sample_last;
    logic                vec_last;

    bit_sync u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (dut_out),
        .q     (dut_sync)
    );

    assign settle_last = (settle_q == SW'(SETTLE_CYCLES - 1));
    assign sample_last = (samp_q == CW'(SAMPLES - 1));
    assign vec_last    = &vec_q;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic for the sweep sequencer.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (start) state_d = StSettle;
            StSettle: if (settle_last) state_d = StSample;
            StSample: if (sample_last) state_d = StReport;
            StReport: begin
                if (result_ready) state_d = vec_last ? StDone : StSettle;
            end
            StDone:   state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Vector, settle/sample counters and the ones/toggle accumulators.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec_q    <= '0;
            settle_q <= '0;
            samp_q   <= '0;
            ones_q   <= '0;
            tog_q    <= '0;
            prev_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    vec_q    <= '0;
                    settle_q <= '0;
                end
                StSettle: begin
                    settle_q <= settle_last ? '0 : settle_q + SW'(1);
                    samp_q   <= '0;
                    ones_q   <= '0;
                    tog_q    <= '0;
                end
                StSample: begin
                    samp_q <= samp_q + CW'(1);
                    ones_q <= ones_q + CW'(dut_sync);
                    // The first sample has no predecessor within this vector.
                    if (samp_q != '0) begin
                        tog_q <= tog_q + CW'(dut_sync != prev_q);
                    end
                    prev_q <= dut_sync;
                end
                StReport: begin
                    // Results stay frozen until accepted; the next vector
                    // appears on dut_in exactly at SETTLE entry.
                    if (result_ready) begin
                        vec_q <= vec_last ? '0 : vec_q + IN_WIDTH'(1);
                    end
                end
                StDone: begin
                    vec_q <= '0;
                end
                default: begin
                    vec_q <= '0;
                end
            endcase
        end
    end

    // Outputs decoded from state and the held accumulators.
    always_comb begin
        busy           = (state_q == StSettle) || (state_q == StSample) ||
                         (state_q == StReport);
        done           = (state_q == StDone);
        result_valid   = (state_q == StReport);
        dut_in         = vec_q;
        result_vec     = vec_q;
        result_ones    = ones_q;
        result_toggles = tog_q;
        result_value   = (ones_q > CW'(SAMPLES / 2));
        // Qualified so the field reads 0 whenever no result is presented.
        result_stable  = (state_q == StReport) && (tog_q == '0);
    end

endmodule

// File: tb/tb_evo_response_sampler.sv
// Self-checking bench: model DUTs drive dut_out, results are compared with a
// reference computed from the sampled-sequence rules.
module tb_evo_response_sampler;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       ready = 1'b1;
    logic       sel = 1'b0;
    logic       mode = 1'b0;   // 0: truth table on dut_in, 1: toggle every clock
    logic [3:0] tbl = 4'b0110;
    logic       tog = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) tog <= ~tog;

    // Default instance.
    logic       busy1, done1, valid1, val1, stb1, dout1;
    logic [1:0] din1, vec1;
    logic [3:0] ones1, tg1;
    // Minimum-size instance.
    logic       busy2, done2, valid2, val2, stb2, dout2;
    logic [1:0] din2, vec2;
    logic [1:0] ones2, tg2;

    assign dout1 = mode ? tog : tbl[din1];
    assign dout2 = mode ? tog : tbl[din2];

    evo_response_sampler u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .busy(busy1), .done(done1),
        .dut_in(din1), .dut_out(dout1), .result_valid(valid1),
        .result_ready(sel ? 1'b1 : ready), .result_vec(vec1), .result_ones(ones1),
        .result_toggles(tg1), .result_value(val1), .result_stable(stb1)
    );

    evo_response_sampler #(.IN_WIDTH(2), .SETTLE_CYCLES(3), .SAMPLES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .busy(busy2), .done(done2),
        .dut_in(din2), .dut_out(dout2), .result_valid(valid2),
        .result_ready(sel ? ready : 1'b1), .result_vec(vec2), .result_ones(ones2),
        .result_toggles(tg2), .result_value(val2), .result_stable(stb2)
    );

    wire        s_busy  = sel ? busy2 : busy1;
    wire        s_done  = sel ? done2 : done1;
    wire        s_valid = sel ? valid2 : valid1;
    wire [1:0]  s_din   = sel ? din2 : din1;
    wire [1:0]  s_vec   = sel ? vec2 : vec1;
    wire [3:0]  s_ones  = sel ? {2'b00, ones2} : ones1;
    wire [3:0]  s_tg    = sel ? {2'b00, tg2} : tg1;
    wire        s_val   = sel ? val2 : val1;
    wire        s_stb   = sel ? stb2 : stb1;
    wire [11:0] s_tuple = {s_vec, s_ones, s_tg, s_val, s_stb};

    // Captured sweep observations.
    logic [11:0] res_tuple [8];
    int n_res, n_done, done_cyc, first_valid, hold_viol, stall_cycles;
    bit timed_out;

    // Reference: list the samples the harness should see and count them.
    function automatic logic [11:0] exp_tuple(input int v, input int s);
        int ones = 0;
        int togs = 0;
        bit cur;
        bit prev = 1'b0;
        for (int i = 0; i < s; i++) begin
            cur = mode ? bit'(i % 2) : bit'(tbl[v]);
            ones += int'(cur);
            if (i > 0 && cur != prev) togs++;
            prev = cur;
        end
        return {2'(v), 4'(ones), 4'(togs), 1'(ones > s / 2), 1'(togs == 0)};
    endfunction

    // Runs one sweep on the selected instance and records what it reports.
    task automatic capture(input int stall_vec, input int stall_len, input bit restart10,
                           input int stall_pct);
        int cyc;
        int stalled;
        int post;
        bit seen_done;
        logic [11:0] snap;
        n_res = 0; n_done = 0; done_cyc = -1; first_valid = -1;
        hold_viol = 0; stall_cycles = 0; timed_out = 0;
        stalled = 0; post = 0; seen_done = 0; snap = '0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        cyc = 1;
        while (post < 30 && cyc < 2000) begin
            @(negedge clk);
            if (restart10) start = (cyc == 10);
            ready = 1'b1;
            if (s_valid) begin
                if (first_valid < 0) first_valid = cyc;
                if (int'(s_vec) == stall_vec && stalled <= stall_len && stall_len > 0) begin
                    if (stalled == 0) snap = s_tuple;
                    else if (s_tuple !== snap || int'(s_din) != stall_vec) hold_viol++;
                    if (stalled < stall_len) ready = 1'b0;
                    stalled++;
                end else if (stall_pct > 0 && $urandom_range(99) < stall_pct) begin
                    ready = 1'b0;
                end
                if (!ready) stall_cycles++;
                else begin
                    if (n_res < 8) res_tuple[n_res] = s_tuple;
                    n_res++;
                end
            end
            if (s_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
                seen_done = 1'b1;
            end
            if (seen_done) post++;
            @(posedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b1;
        if (!seen_done) timed_out = 1'b1;
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if ({busy1, done1, valid1, din1, s_tuple} !== '0) begin
            errors++;
            $display("FAIL reset_dut1: got busy=%b done=%b valid=%b din=%0d fields=%h, want all 0",
                     busy1, done1, valid1, din1, {vec1, ones1, tg1, val1, stb1});
        end
        checks++;
        if ({busy2, done2, valid2, din2, vec2, ones2, tg2, val2, stb2} !== '0) begin
            errors++;
            $display("FAIL reset_dut2: got busy=%b done=%b valid=%b din=%0d, want all 0",
                     busy2, done2, valid2, din2);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_xor();
        sel = 1'b0; mode = 1'b0; tbl = 4'b0110;
        capture(-1, 0, 1'b0, 0);
        checks++;
        if (timed_out || n_res != 4) begin
            errors++;
            $display("FAIL xor_count: got %0d results (timeout=%0b), want 4", n_res, timed_out);
        end
        for (int i = 0; i < 4 && i < n_res; i++) begin
            checks++;
            if (res_tuple[i] !== exp_tuple(i, 8)) begin
                errors++;
                $display("FAIL xor_result%0d: got %h, want %h", i, res_tuple[i], exp_tuple(i, 8));
            end
        end
        checks++;
        if (first_valid != 25) begin
            errors++;
            $display("FAIL xor_first_valid: got cycle %0d, want 25", first_valid);
        end
        checks++;
        if (done_cyc != 101 || n_done != 1) begin
            errors++;
            $display("FAIL xor_done: got cycle %0d x%0d, want cycle 101 x1", done_cyc, n_done);
        end
    endtask

    task automatic test_toggle();
        sel = 1'b0; mode = 1'b1;
        capture(-1, 0, 1'b0, 0);
        checks++;
        if (n_res != 4) begin
            errors++;
            $display("FAIL toggle_count: got %0d results, want 4", n_res);
        end
        for (int i = 0; i < 4 && i < n_res; i++) begin
            checks++;
            if (res_tuple[i] !== exp_tuple(i, 8)) begin
                errors++;
                $display("FAIL toggle_result%0d: got %h, want %h", i, res_tuple[i],
                         exp_tuple(i, 8));
            end
        end
        mode = 1'b0;
    endtask

    task automatic test_stall();
        sel = 1'b0; mode = 1'b0; tbl = 4'b0110;
        capture(1, 5, 1'b0, 0);
        checks++;
        if (hold_viol != 0 || stall_cycles != 5) begin
            errors++;
            $display("FAIL stall_hold: got %0d changes over %0d stalls, want 0 over 5",
                     hold_viol, stall_cycles);
        end
        checks++;
        if (done_cyc != 106) begin
            errors++;
            $display("FAIL stall_done: got cycle %0d, want 106", done_cyc);
        end
        for (int i = 0; i < 4 && i < n_res; i++) begin
            checks++;
            if (res_tuple[i] !== exp_tuple(i, 8)) begin
                errors++;
                $display("FAIL stall_result%0d: got %h, want %h", i, res_tuple[i],
                         exp_tuple(i, 8));
            end
        end
    endtask

    task automatic test_restart_ignored();
        sel = 1'b0; mode = 1'b0; tbl = 4'b1001;
        capture(-1, 0, 1'b1, 0);
        checks++;
        if (n_res != 4 || n_done != 1 || done_cyc != 101) begin
            errors++;
            $display("FAIL restart: got %0d results %0d done at %0d, want 4 1 at 101",
                     n_res, n_done, done_cyc);
        end
    endtask

    task automatic test_reset_midsweep();
        sel = 1'b0; mode = 1'b0; tbl = 4'b0110;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        checks++;
        if (busy1 !== 1'b1) begin
            errors++;
            $display("FAIL midreset_pre_busy: got %b, want 1", busy1);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy1, din1, valid1, done1} !== 5'b0) begin
            errors++;
            $display("FAIL midreset_outputs: got busy=%b din=%0d valid=%b done=%b, want 0",
                     busy1, din1, valid1, done1);
        end
        @(negedge clk);
        rst_n = 1'b1;
        capture(-1, 0, 1'b0, 0);
        checks++;
        if (n_res != 4 || done_cyc != 101) begin
            errors++;
            $display("FAIL midreset_sweep: got %0d results done at %0d, want 4 at 101",
                     n_res, done_cyc);
        end
        for (int i = 0; i < 4 && i < n_res; i++) begin
            checks++;
            if (res_tuple[i] !== exp_tuple(i, 8)) begin
                errors++;
                $display("FAIL midreset_result%0d: got %h, want %h", i, res_tuple[i],
                         exp_tuple(i, 8));
            end
        end
    endtask

    task automatic test_small();
        sel = 1'b1; mode = 1'b0; tbl = 4'b1111;
        capture(-1, 0, 1'b0, 0);
        checks++;
        if (n_res != 4 || first_valid != 6 || done_cyc != 25) begin
            errors++;
            $display("FAIL small_timing: got %0d results valid@%0d done@%0d, want 4 6 25",
                     n_res, first_valid, done_cyc);
        end
        for (int i = 0; i < 4 && i < n_res; i++) begin
            checks++;
            if (res_tuple[i] !== exp_tuple(i, 2)) begin
                errors++;
                $display("FAIL small_result%0d: got %h, want %h", i, res_tuple[i],
                         exp_tuple(i, 2));
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int r = 0; r < 6; r++) begin
            sel  = r[0];
            mode = ($urandom_range(3) == 0) && !sel;
            tbl  = 4'($urandom);
            capture(-1, 0, 1'b0, 30);
            checks++;
            if (n_res != 4 || done_cyc != (sel ? 25 : 101) + stall_cycles) begin
                errors++;
                $display("FAIL rand%0d_sweep: got %0d results done@%0d, want 4 done@%0d",
                         r, n_res, done_cyc, (sel ? 25 : 101) + stall_cycles);
            end
            for (int i = 0; i < 4 && i < n_res; i++) begin
                checks++;
                if (res_tuple[i] !== exp_tuple(i, sel ? 2 : 8)) begin
                    errors++;
                    $display("FAIL rand%0d_result%0d: got %h, want %h", r, i, res_tuple[i],
                             exp_tuple(i, sel ? 2 : 8));
                end
            end
        end
        sel = 1'b0; mode = 1'b0;
    endtask

    initial begin
        test_reset();
        test_xor();
        test_toggle();
        test_stall();
        test_restart_ignored();
        test_reset_midsweep();
        test_small();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
